// File: rtl/pipe_barrel_shifter_if.sv
// pipe_barrel_shifter_if
//   Operation/result bundle for pipe_barrel_shifter.
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1. Once valid is raised, the payload on that side stays stable
//   until the transfer completes.
//   Signals:
//     in_valid/in_ready    operation handshake
//     in_data              operand (WIDTH)
//     in_shamt             shift amount (SH_W)
//     in_mode              00=SLL 01=SRL 10=SRA 11=ROR
//     in_tag               opaque tag, returned with the result
//     out_valid/out_ready  result handshake
//     out_data/out_tag     result and its tag
//   Modports: master = operation source / result sink, slave = shifter.
interface pipe_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SH_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SH_W-1:0]  in_shamt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter
//   Fully pipelined barrel shifter supporting SLL, SRL, SRA and, optionally, ROR.
//   There is one log-shift stage per shift-amount bit, and each stage has an
//   output register. The largest shift is applied first, so for WIDTH=32 the
//   stage order is 16, 8, 4, 2, 1. Latency is SH_W cycles and throughput is
//   one operation per cycle.
//   Flow control is a global stall: when the last stage holds a result that
//   is not taken, every stage holds and in_ready drops. Bubbles are not
//   collapsed.
//   Optional feature: define BSHIFT_ROTATE_EN to build the ROR wrap path.
//   Without it, mode 11 behaves as SRL.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; discards all in-flight operations
//     bus    pipe_barrel_shifter_if.slave (operation in, result out)
//     busy   at least one stage holds a valid operation
module pipe_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_barrel_shifter_if.slave  bus,
  output logic                  busy
);
  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] vld_vec;
  logic            stall;

  // Single shift step by a fixed, non-zero amount.
  // For SRA, the fill uses the sign of the original operand, which is
  // carried alongside the data. By later stages, the data MSB may already
  // be fill, so it cannot stand in for the sign.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input int               amt,
    input logic [1:0]       mode,
    input logic             sign
  );
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> amt);
    case (mode)
      2'b00:   stage_shift = d << amt;
      2'b10:   stage_shift = (d >> amt) | (sign ? fill : '0);
`ifdef BSHIFT_ROTATE_EN
      2'b11:   stage_shift = (d >> amt) | (d << (WIDTH - amt));
`endif
      default: stage_shift = d >> amt;
    endcase
  endfunction

  assign stall        = vld_vec[SH_W-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign busy         = |vld_vec;

  genvar k;
  for (k = 0; k < SH_W; k++) begin : g_stage
    localparam int AMT = 1 << (SH_W - 1 - k);

    logic [WIDTH-1:0] d_in, data_q;
    logic [SH_W-1:0]  sh_in, shamt_q;
    logic [1:0]       m_in, mode_q;
    logic [TAG_W-1:0] t_in, tag_q;
    logic             s_in, sign_q;
    logic             v_in, vld_q;
    logic             unused_sh;

    if (k == 0) begin : g_src
      assign d_in  = bus.in_data;
      assign sh_in = bus.in_shamt;
      assign m_in  = bus.in_mode;
      assign t_in  = bus.in_tag;
      assign s_in  = bus.in_data[WIDTH-1];
      assign v_in  = bus.in_valid;
    end else begin : g_src
      assign d_in  = g_stage[k-1].data_q;
      assign sh_in = g_stage[k-1].shamt_q;
      assign m_in  = g_stage[k-1].mode_q;
      assign t_in  = g_stage[k-1].tag_q;
      assign s_in  = g_stage[k-1].sign_q;
      assign v_in  = g_stage[k-1].vld_q;
    end

    // Each stage looks at only one shamt bit; the others just ride along.
    assign unused_sh = ^sh_in;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        shamt_q <= '0;
        mode_q  <= '0;
        tag_q   <= '0;
        sign_q  <= 1'b0;
        vld_q   <= 1'b0;
      end else if (!stall) begin
        data_q  <= sh_in[SH_W-1-k] ? stage_shift(d_in, AMT, m_in, s_in) : d_in;
        shamt_q <= sh_in;
        mode_q  <= m_in;
        tag_q   <= t_in;
        sign_q  <= s_in;
        vld_q   <= v_in;
      end
    end

    assign vld_vec[k] = vld_q;
  end

  assign bus.out_valid = g_stage[SH_W-1].vld_q;
  assign bus.out_data  = g_stage[SH_W-1].data_q;
  assign bus.out_tag   = g_stage[SH_W-1].tag_q;

  // The last stage's control fields have no consumer downstream.
  logic unused_tail;
  assign unused_tail = ^{g_stage[SH_W-1].shamt_q, g_stage[SH_W-1].mode_q,
                         g_stage[SH_W-1].sign_q};
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb_pipe_barrel_shifter
//   Directed bench for pipe_barrel_shifter. It exercises a WIDTH=32 instance
//   and a WIDTH=8 instance, using hand-computed expected values.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled on
//   the falling edge.
module tb_pipe_barrel_shifter;
  localparam int SH_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, busy8;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_lat = 1'b1;

  logic [31:0] exp_q[$];
  logic [3:0]  tag_q[$];
  int          acc_q[$];

  pipe_barrel_shifter_if #(.WIDTH(32), .TAG_W(4)) bus ();
  pipe_barrel_shifter_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

  pipe_barrel_shifter #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  pipe_barrel_shifter #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .busy(busy8)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        logic [31:0] ed;
        logic [3:0]  et;
        int          la;
        ed = exp_q.pop_front();
        et = tag_q.pop_front();
        la = acc_q.pop_front();
        check("out_data", bus.out_data, ed);
        check("out_tag", {28'd0, bus.out_tag}, {28'd0, et});
        if (chk_lat) check("latency", cyc - la, SH_W);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                      input logic [3:0] t, input logic [31:0] e);
    int w;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_mode  = m;
    bus.in_tag   = t;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", {31'd0, bus.in_ready}, 32'd1);
    end else begin
      exp_q.push_back(e);
      tag_q.push_back(t);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  // ---------------- directed vectors ----------------
`ifdef BSHIFT_ROTATE_EN
  localparam logic [31:0] ROR_E0 = 32'h8000_0000;
  localparam logic [31:0] ROR_E1 = 32'h7812_3456;
`else
  localparam logic [31:0] ROR_E0 = 32'h0000_0000;
  localparam logic [31:0] ROR_E1 = 32'h0012_3456;
`endif

  logic [31:0] s_d[12] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'h7000_000F, 32'hA5A5_A5A5, 32'h0000_0001,
                           32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
  logic [4:0]  s_sh[12] = '{5'd31, 5'd4, 5'd16, 5'd31, 5'd31, 5'd3, 5'd0, 5'd1,
                            5'd8, 5'd4, 5'd31, 5'd1};
  logic [1:0]  s_m[12] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11,
                           2'b11, 2'b00, 2'b10, 2'b01};
  logic [31:0] s_e[12] = '{32'h0000_0001, 32'hF800_0000, 32'h0001_0000, 32'h8000_0000,
                           32'hFFFF_FFFF, 32'h0E00_0001, 32'hA5A5_A5A5, ROR_E0,
                           ROR_E1, 32'h2345_6780, 32'hFFFF_FFFF, 32'h4000_0000};

  logic [31:0] b2b_e[8] = '{32'hF000_0000, 32'hF800_0000, 32'hFC00_0000, 32'hFE00_0000,
                            32'hFF00_0000, 32'hFF80_0000, 32'hFFC0_0000, 32'hFFE0_0000};

  logic [31:0] st_e[6] = '{32'h0000_0003, 32'h0000_0030, 32'h0000_0300,
                           32'h0000_3000, 32'h0003_0000, 32'h0030_0000};

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0; bus.in_mode = '0;
    bus.in_tag = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_shamt = '0; bus8.in_mode = '0;
    bus8.in_tag = '0; bus8.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single operations: fill, latency, rotate, shamt=0
    for (int i = 0; i < 12; i++) begin
      send(s_d[i], s_sh[i], s_m[i], i[3:0], s_e[i]);
      idle();
      drain("single_drain");
    end

    // Back-to-back SRA, shamt 0..7
    for (int i = 0; i < 8; i++) send(32'hF000_0000, i[4:0], 2'b10, i[3:0], b2b_e[i]);
    idle();
    drain("b2b_drain");

    // Stall with a full pipe
    chk_lat = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'h3, 5'(i * 4), 2'b00, 4'(8 + i), st_e[i]);
        idle();
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 40) begin
          @(negedge clk);
          w++;
        end
        for (int c = 0; c < 3; c++) begin
          if (c != 0) @(negedge clk);
          check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
          check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
          check("stall_out_data", bus.out_data, 32'h0000_0003);
          check("stall_out_tag", {28'd0, bus.out_tag}, 32'd8);
          check("stall_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stall_drain");
    chk_lat = 1'b1;

    // Reset with three operations in flight
    for (int i = 1; i <= 3; i++) send(32'h1, 5'd1, 2'b00, i[3:0], 32'h2);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q.delete();
    tag_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);

    // WIDTH=8: SLL 0x81 by 7 -> 0x80 after 3 cycles
    begin
      int lat;
      lat = 0;
      @(posedge clk); #1;
      bus8.in_valid = 1'b1;
      bus8.in_data  = 8'h81;
      bus8.in_shamt = 3'd7;
      bus8.in_mode  = 2'b00;
      bus8.in_tag   = 4'd5;
      @(negedge clk);
      check("w8_in_ready", {31'd0, bus8.in_ready}, 32'd1);
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (bus8.out_valid) begin
          lat = n;
          break;
        end
      end
      check("w8_latency", lat, 32'd3);
      check("w8_data", {24'd0, bus8.out_data}, 32'h0000_0080);
      check("w8_tag", {28'd0, bus8.out_tag}, 32'd5);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_barrel_shifter.md
Name: pipe_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter. It succeeds the fixed 32-bit logical right shifter and supports SLL, SRL, SRA and an optional ROR.
- One log-shift stage per shift-amount bit, with a register after every stage.
- Valid/ready handshake on input and output, so it drops into the ALU datapath between operand fetch and writeback.
- An opaque tag travels alongside each operation for result steering.

Parameters:
WIDTH, 32, data width; must be a power of 2 and at least 4.
TAG_W, 4, width of the pass-through tag; must be at least 1.
SH_W, $clog2(WIDTH), shift-amount width and stage count; derived, not overridden.

Ports:
clk  in  1  clock; all state on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input operation valid.
in_ready  out  1  shifter can accept the operation this cycle.
in_data  in  WIDTH  operand.
in_shamt  in  SH_W  shift amount, 0..WIDTH-1.
in_mode  in  2  00=SLL, 01=SRL, 10=SRA, 11=ROR.
in_tag  in  TAG_W  user tag, returned unchanged.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  shifted result.
out_tag  out  TAG_W  tag of the result.
busy  out  1  at least one stage holds a valid operation.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: every stage valid bit, data, shamt, mode and tag register clears to 0. So out_valid=0, out_data=0, out_tag=0, busy=0, and in_ready=1 right after reset.
- Reset mid-operation: all in-flight operations are discarded and none reaches the output.
- Pipeline structure: SH_W stages, stage k = 0..SH_W-1.
  - Stage k applies a shift of 2^(SH_W-1-k) when bit (SH_W-1-k) of the carried shamt is 1, otherwise passes data through. For WIDTH=32 the order is 16, 8, 4, 2, 1.
  - Each stage registers data, shamt, mode, tag and valid.
- Latency: exactly SH_W cycles from the accepting edge (in_valid & in_ready) to out_valid=1, absent stalls. Throughput is one operation per cycle.
- Fill per mode:
  - SLL: zero-fill at the LSB end.
  - SRL: zero-fill at the MSB end.
  - SRA: fill with bit WIDTH-1 of the original operand. The sign bit is carried per stage so every stage fills correctly.
  - ROR: bits shifted out of the LSB end re-enter at the MSB end.
- shamt=0: output equals the input for all modes, after SH_W cycles.
- Flow control (global stall):
  - stall = out_valid & ~out_ready.
  - While stall=1, every stage register holds and in_ready=0.
  - With no stall, every stage advances, in_ready=1, and bubbles propagate as valid=0.
- No bubble collapsing; a bubble ahead of a stall is kept.
- Simultaneous events: when out_ready=1 and in_valid=1 in the same cycle with the pipe full, both the output handoff and the input acceptance occur.
- Output stability: out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- busy = OR of all stage valid bits.
- Ordering: results emerge in acceptance order. Tags are never reordered or duplicated.

Optional Feature:
Macro: BSHIFT_ROTATE_EN
- Defined: mode 11 performs ROR as described in Behaviour.
- Undefined: the rotate wrap path is not built, and mode 11 behaves exactly as SRL (zero-fill). Latency and handshake are unchanged.

Test Plan:
- Fill and latency (WIDTH=32): SRL of 0x80000000, shamt=31, out_ready=1 -> out_data=0x00000001 with out_valid exactly 5 cycles after acceptance; SRA of 0x80000000, shamt=4 -> 0xF8000000; SLL of 0x00000001, shamt=16 -> 0x00010000.
- Back-to-back: 8 operations on consecutive cycles (shamt 0..7, mode SRA, data 0xF0000000, tags 0..7) -> 8 consecutive results, tags 0..7 in order, shamt=0 result=0xF0000000.
- Stall: hold out_ready=0 for 3 cycles while the pipe is full -> in_ready=0, out_data and out_tag constant; on release, no result lost or duplicated.
- Rotate: ROR of 0x00000001, shamt=1 -> 0x80000000 with BSHIFT_ROTATE_EN defined; 0x00000000 without it.
- Reset mid-operation: assert rst_n=0 asynchronously (mid-cycle) with 3 operations in flight -> out_valid=0 and busy=0 immediately; no stale result after release.
- Parametrisation: WIDTH=8, SLL of 0x81, shamt=7 -> 0x80 after 3 cycles.
